// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//
// Edge feeder for an N x N systolic multiply array. Holds operand matrices
// A and B (loaded one element at a time while idle) and, on start, streams
// A rows into the array's left edge and B columns into its top edge with
// the diagonal skew the array needs. Zeros fill every slot outside a
// row's or column's window. After the last operand the feeder flushes zeros
// until cell (N-1,N-1) has its final sum, then pulses done.
//
// Ports
//   clock    rising-edge clock
//   nreset   asynchronous active-low reset
//   wr_en    write one matrix element (IDLE only)
//   wr_sel   0 = A, 1 = B
//   wr_row   element row index (indices >= N are dropped)
//   wr_col   element column index (indices >= N are dropped)
//   wr_data  element value
//   start    begin streaming (IDLE only)
//   a_out    left-edge feed, row i on a_out[i*WIDTH +: WIDTH]
//   b_out    top-edge feed, column j on b_out[j*WIDTH +: WIDTH]
//   busy     high while streaming or flushing
//   done     one-cycle pulse once all array accumulators are final
//
// state  | meaning
// IDLE   | accept element writes, wait for start
// STREAM | feed skewed operands, step s = 0 .. 2N-2
// FLUSH  | feed zeros, step s = 2N-1 .. 3N-3
// DONE   | single-cycle done pulse, then back to IDLE

module systolic_skew_feeder #(
   parameter int WIDTH = 16,
   parameter int N = 4,
   localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clock,
   input  logic                 nreset,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [IDXW-1:0]      wr_row,
   input  logic [IDXW-1:0]      wr_col,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 start,
   output logic [N*WIDTH-1:0]   a_out,
   output logic [N*WIDTH-1:0]   b_out,
   output logic                 busy,
   output logic                 done
);

   localparam int SW = $clog2(3 * N);
   localparam logic [SW-1:0] S_STREAM_LAST = SW'(2 * N - 2);
   localparam logic [SW-1:0] S_FLUSH_LAST  = SW'(3 * N - 3);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        s_q, s_d;
   logic [WIDTH-1:0]     a_q [N][N];
   logic [WIDTH-1:0]     a_d [N][N];
   logic [WIDTH-1:0]     b_q [N][N];
   logic [WIDTH-1:0]     b_d [N][N];
   logic [N*WIDTH-1:0]   a_out_q, a_out_d;
   logic [N*WIDTH-1:0]   b_out_q, b_out_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 feed_en;
   int                   feed_s;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      a_d     = a_q;
      b_d     = b_q;
      a_out_d = '0;
      b_out_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      feed_en = 1'b0;
      feed_s  = 0;

      case (state_q)
         IDLE: begin
            // Loop compare instead of direct indexing so out-of-range
            // indices simply match nothing.
            if (wr_en) begin
               for (int r = 0; r < N; r++) begin
                  for (int c = 0; c < N; c++) begin
                     if (int'(wr_row) == r && int'(wr_col) == c) begin
                        if (wr_sel) b_d[r][c] = wr_data;
                        else        a_d[r][c] = wr_data;
                     end
                  end
               end
            end
            if (start) begin
               state_d = STREAM;
               s_d     = '0;
               busy_d  = 1'b1;
               feed_en = 1'b1;
               feed_s  = 0;
            end
         end
         STREAM: begin
            busy_d = 1'b1;
            s_d    = s_q + SW'(1);
            if (s_q == S_STREAM_LAST) begin
               if (N == 1) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = FLUSH;
               end
            end else begin
               feed_en = 1'b1;
               feed_s  = int'(s_q) + 1;
            end
         end
         FLUSH: begin
            busy_d = 1'b1;
            s_d    = s_q + SW'(1);
            if (s_q == S_FLUSH_LAST) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            s_d     = '0;
         end
         default: begin
            state_d = IDLE;
            s_d     = '0;
         end
      endcase

      // Row i carries A[i][k] and column i carries B[k][i] at step i+k.
      // Reads use the post-write storage so a write coinciding with start
      // is already visible in step 0.
      if (feed_en) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (feed_s == i + k) begin
                  a_out_d[i*WIDTH +: WIDTH] = a_d[i][k];
                  b_out_d[i*WIDTH +: WIDTH] = b_d[k][i];
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         s_q     <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_q[r][c] <= '0;
               b_q[r][c] <= '0;
            end
         end
         a_out_q <= '0;
         b_out_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         a_q     <= a_d;
         b_q     <= b_d;
         a_out_q <= a_out_d;
         b_out_q <= b_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign a_out = a_out_q;
   assign b_out = b_out_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: an N=4 instance driven with random and
// directed operand matrices, and an N=1 instance for the degenerate case.
// Expected edge feeds come from per-step tables built from the matrices.

module tb_systolic_skew_feeder;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int IW = 2;

   logic clock = 1'b0;
   logic nreset;
   always #5 clock = ~clock;

   logic            wr_en, wr_sel, start;
   logic [IW-1:0]   wr_row, wr_col;
   logic [W-1:0]    wr_data;
   logic [N*W-1:0]  a_out, b_out;
   logic            busy, done;

   logic            w1_en, w1_sel, start1;
   logic [0:0]      w1_row, w1_col;
   logic [W-1:0]    w1_data;
   logic [W-1:0]    a1_out, b1_out;
   logic            busy1, done1;

   systolic_skew_feeder #(.WIDTH(W), .N(N)) dut (
      .clock(clock), .nreset(nreset),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .start(start),
      .a_out(a_out), .b_out(b_out), .busy(busy), .done(done)
   );

   systolic_skew_feeder #(.WIDTH(W), .N(1)) dut1 (
      .clock(clock), .nreset(nreset),
      .wr_en(w1_en), .wr_sel(w1_sel), .wr_row(w1_row), .wr_col(w1_col),
      .wr_data(w1_data), .start(start1),
      .a_out(a1_out), .b_out(b1_out), .busy(busy1), .done(done1)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0] ma [N][N];
   logic [W-1:0] mb [N][N];

   task automatic check(input string tag, input logic [N*W-1:0] obs,
                        input logic [N*W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_elem(input logic sel, input int r, input int c,
                             input logic [W-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Everything except B[N-1][N-1], which goes in alongside start.
   task automatic load_all();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            write_elem(1'b0, r, c, ma[r][c]);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (!(r == N - 1 && c == N - 1)) write_elem(1'b1, r, c, mb[r][c]);
   endtask

   task automatic run_stream(input bit with_write, input bit disturb,
                             input string name);
      logic [N*W-1:0] ea [3*N];
      logic [N*W-1:0] eb [3*N];
      for (int s = 0; s < 3 * N; s++) begin
         ea[s] = '0;
         eb[s] = '0;
      end
      // Row i is i zeros, then A[i][0..N-1]; column j is j zeros, then B[0..N-1][j].
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ea[i + k][i*W +: W] = ma[i][k];
            eb[i + k][i*W +: W] = mb[k][i];
         end
      start = 1'b1;
      if (with_write) begin
         wr_en = 1'b1; wr_sel = 1'b1; wr_row = IW'(N - 1); wr_col = IW'(N - 1);
         wr_data = mb[N-1][N-1];
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      for (int c = 0; c <= 3 * N - 2; c++) begin
         if (c > 0) tick();
         if (disturb && c == 2) begin
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
            wr_row = '0; wr_col = '0; wr_data = 16'd99;
         end
         if (disturb && c == 3) begin
            start = 1'b0; wr_en = 1'b0;
         end
         check($sformatf("%s a_out c%0d", name, c), a_out, (c <= 2*N-2) ? ea[c] : '0);
         check($sformatf("%s b_out c%0d", name, c), b_out, (c <= 2*N-2) ? eb[c] : '0);
         check($sformatf("%s busy c%0d", name, c), {63'd0, busy}, {63'd0, c < 3*N-2});
         check($sformatf("%s done c%0d", name, c), {63'd0, done}, {63'd0, c == 3*N-2});
      end
      tick();
      check({name, " done after"}, {63'd0, done}, '0);
      check({name, " busy after"}, {63'd0, busy}, '0);
      check({name, " a_out after"}, a_out, '0);
   endtask

   initial begin
      nreset = 1'b0;
      wr_en = 0; wr_sel = 0; wr_row = '0; wr_col = '0; wr_data = '0; start = 0;
      w1_en = 0; w1_sel = 0; w1_row = '0; w1_col = '0; w1_data = '0; start1 = 0;
      #12 nreset = 1'b1;
      tick();
      check("reset a_out", a_out, '0);
      check("reset b_out", b_out, '0);
      check("reset busy", {63'd0, busy}, '0);
      check("reset done", {63'd0, done}, '0);
      check("reset done1", {63'd0, done1}, '0);

      // Random operands, last write coinciding with start.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = W'($urandom);
            mb[r][c] = W'($urandom);
         end
      load_all();
      run_stream(1'b1, 1'b0, "rand");
      // Replay; start/wr_en pulsed mid-stream must be ignored.
      run_stream(1'b0, 1'b1, "replay");
      run_stream(1'b0, 1'b0, "replay2");

      // Identity A, B[r][c] = 4r+c+1.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (r == c) ? W'(1) : W'(0);
            mb[r][c] = W'(4 * r + c + 1);
         end
      load_all();
      run_stream(1'b1, 1'b0, "ident");

      // Asynchronous reset at s=1.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 nreset = 1'b0;
      #1;
      check("midrst a_out", a_out, '0);
      check("midrst b_out", b_out, '0);
      check("midrst busy", {63'd0, busy}, '0);
      check("midrst done", {63'd0, done}, '0);
      tick();
      nreset = 1'b1;
      for (int c = 0; c < 3 * N; c++) begin
         tick();
         check($sformatf("postrst done c%0d", c), {63'd0, done}, '0);
         check($sformatf("postrst busy c%0d", c), {63'd0, busy}, '0);
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
         end
      run_stream(1'b0, 1'b0, "cleared");

      // N=1: A=7, B=9; an out-of-range write must not land.
      w1_en = 1'b1; w1_sel = 1'b0; w1_row = 1'b0; w1_col = 1'b0; w1_data = 16'd7;
      tick();
      w1_row = 1'b1; w1_data = 16'd55;
      tick();
      w1_sel = 1'b1; w1_row = 1'b0; w1_data = 16'd9;
      tick();
      w1_en = 1'b0;
      for (int run = 0; run < 2; run++) begin
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         check($sformatf("n1 r%0d a_out s0", run), {48'd0, a1_out}, 64'd7);
         check($sformatf("n1 r%0d b_out s0", run), {48'd0, b1_out}, 64'd9);
         check($sformatf("n1 r%0d busy s0", run), {63'd0, busy1}, 64'd1);
         check($sformatf("n1 r%0d done s0", run), {63'd0, done1}, 64'd0);
         tick();
         check($sformatf("n1 r%0d done", run), {63'd0, done1}, 64'd1);
         check($sformatf("n1 r%0d busy at done", run), {63'd0, busy1}, 64'd0);
         check($sformatf("n1 r%0d a_out at done", run), {48'd0, a1_out}, 64'd0);
         check($sformatf("n1 r%0d b_out at done", run), {48'd0, b1_out}, 64'd0);
         tick();
         check($sformatf("n1 r%0d done after", run), {63'd0, done1}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream edge stage of the N×N systolic multiply array built from accumulator_cells.
- Holds operand matrices A and B, loaded element-by-element.
- On start, drives the array's left edge (A rows) and top edge (B columns) with the diagonal time skew the array needs, inserting zeros outside each row's or column's window.
- Flushes with zeros until the last cell has accumulated, then pulses done.

Parameters:
WIDTH, 16, element width; matches accumulator_cells WIDTH.
N, 4, array dimension (N ≥ 1); A and B are N×N.
IDXW, max(1,$clog2(N)), localparam, row/col index width.

Ports:
clock  in  1  rising-edge clock.
nreset  in  1  asynchronous active-low reset.
wr_en  in  1  write one matrix element this cycle.
wr_sel  in  1  0 = write A, 1 = write B.
wr_row  in  IDXW  element row index.
wr_col  in  IDXW  element column index.
wr_data  in  WIDTH  element value.
start  in  1  begin streaming (sampled in IDLE only).
a_out  out  N*WIDTH  left-edge feed; row i on a_out[i*WIDTH +: WIDTH].
b_out  out  N*WIDTH  top-edge feed; column j on b_out[j*WIDTH +: WIDTH].
busy  out  1  high in STREAM and FLUSH.
done  out  1  one-cycle pulse: all array accumulators are final.

Behaviour:
Reset (nreset low, asynchronous):
- State goes to IDLE.
- A, B storage, a_out, b_out, busy, done and step counter all go to 0.
- Reset is honoured in any state, including mid-stream; streaming aborts with no done pulse.

Load:
- In IDLE, wr_en writes wr_data to A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the clock edge.
- Indices ≥ N are ignored.
- wr_en is ignored outside IDLE.
- If wr_en and start are high in the same IDLE cycle, the write commits and is visible to the stream.

State machine:
- IDLE -> STREAM when start=1. The step counter s is cleared to 0.
- STREAM holds for 2N-1 cycles (s = 0..2N-2), then goes to FLUSH (or to DONE if N=1).
- FLUSH holds for N-1 cycles with s continuing to increment, then goes to DONE.
- DONE lasts one cycle, then returns to IDLE.
- start outside IDLE is ignored.

Outputs:
- All outputs are registered; values for step s appear in the first cycle of step s.
- a_out row i = A[i][s-i] when 0 ≤ s-i < N, else 0.
- b_out column j = B[s-j][j] when 0 ≤ s-j < N, else 0.
- In FLUSH, DONE and IDLE, a_out and b_out are 0.
- done=1 only in the DONE cycle, which is 3N-2 cycles after the first STREAM cycle. By then, cell (N-1,N-1) has captured its final product, given the array's one-register-per-hop forwarding.
- busy=1 in STREAM and FLUSH, and 0 in DONE and IDLE.

Arithmetic and storage:
- No arithmetic; values pass through unmodified.
- A and B retain their contents across runs, so a second start replays the same operands.
- The array accumulators are not cleared by this block. The system must reset the array between runs.

Test Plan:
- Reset mid-STREAM (assert nreset low at s=1) -> a_out, b_out, busy and done all 0 immediately (asynchronous); state returns to IDLE; no done pulse follows; stored A and B read back as 0 on the next run.
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> over s0..s2:
  - a_out row0 = 1, 2, 0; row1 = 0, 3, 4.
  - b_out col0 = 5, 7, 0; col1 = 0, 6, 8.
  - s3 (FLUSH): all zeros, busy=1.
  - s4: done=1, busy=0.
- Same N=2 operands, feeder connected to a 2×2 accumulator_cells array (array reset beforehand) -> at the done cycle, z = [[19,22],[43,50]].
- N=4, A = identity, B[r][c] = 4r+c+1, start -> done exactly 10 cycles after the first STREAM cycle; array z equals B.
- start and wr_en pulsed during busy (wr_en writing A[0][0]=99) -> no restart and no storage change. A second start after done replays identical a_out and b_out sequences.
- N=1, A=[[7]], B=[[9]] -> a_out=7 and b_out=9 for one cycle, no FLUSH, done on the next cycle; array z = 63.
